// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Target end of the core's active-low data-memory port. Holds DEPTH = 2**AW
//   words and writes them on the rising clock edge. Reads return data with a
//   latency of 0 (combinational) or 1 (registered) cycles. It also keeps
//   saturating read/write counters and a sticky protocol-error flag for debug.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   CEN, WEN, OEN       chip / write / output enables, all active low
//   A                   word address (covers the full DEPTH)
//   Data2Mem            write data
//   ReadDataMem         read data
//   rd_valid            ReadDataMem carries a fresh read result this cycle
//   rd_cnt, wr_cnt      accepted read / write counts, saturating
//   proto_err           sticky: a write and a read were requested in the same cycle
module data_mem_responder #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned AW           = 7,
  parameter int unsigned DW           = 32,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CEN,
  input  logic             WEN,
  input  logic             OEN,
  input  logic [AW-1:0]    A,
  input  logic [DW-1:0]    Data2Mem,
  output logic [DW-1:0]    ReadDataMem,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             proto_err
);

  localparam int unsigned      DEPTH   = 2**AW;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DW-1:0] mem_q [DEPTH];

  // A conflict cycle (WEN=0 and OEN=0) counts as both a write and a read.
  logic wr_acc;
  logic rd_acc;
  assign wr_acc = !CEN && !WEN;
  assign rd_acc = !CEN && !OEN;

  // The array is not reset, so its contents survive reset. Writes are still
  // blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem_q[A] <= Data2Mem;
    end
  end

  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             proto_err_q, proto_err_d;

  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    proto_err_d = proto_err_q;
    if (rd_acc && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_ONE;
    if (wr_acc && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_ONE;
    if (rd_acc && wr_acc)           proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign proto_err = proto_err_q;

  if (READ_LATENCY == 0) begin : g_lat0
    // Read is combinational, so a conflict cycle returns the word as it was
    // before the write. The write lands on the edge.
    logic rd_live;
    always_comb begin
      rd_live     = rst_n && rd_acc;
      rd_valid    = rd_live;
      ReadDataMem = rd_live ? mem_q[A] : '0;
    end
  end else begin : g_lat1
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rd_valid_q;

    // Conflicts are write-first: the output register captures the incoming
    // data, not the old word. The register holds its value when no read is accepted.
    always_comb begin
      rdata_d = rdata_q;
      if (rd_acc) rdata_d = wr_acc ? Data2Mem : mem_q[A];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q    <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rdata_q    <= rdata_d;
        rd_valid_q <= rd_acc;
      end
    end

    assign ReadDataMem = rdata_q;
    assign rd_valid    = rd_valid_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. It drives three instances from the same inputs:
//   dA: READ_LATENCY=1, CNT_W=16
//   dB: READ_LATENCY=0, CNT_W=16
//   dC: READ_LATENCY=1, CNT_W=4
// A behavioural model (a word array plus plain counters) sets the expected outputs.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CEN = 1'b1, WEN = 1'b1, OEN = 1'b1;
  logic [6:0]  A = '0;
  logic [31:0] D = '0;

  always #5 clk = ~clk;

  logic [31:0] rdA, rdB, rdC;
  logic        vA, vB, vC, peA, peB, peC;
  logic [15:0] rcA, wcA, rcB, wcB;
  logic [3:0]  rcC, wcC;

  data_mem_responder #(.READ_LATENCY(1), .AW(7), .DW(32), .CNT_W(16)) dA (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(D),
    .ReadDataMem(rdA), .rd_valid(vA), .rd_cnt(rcA), .wr_cnt(wcA), .proto_err(peA));
  data_mem_responder #(.READ_LATENCY(0), .AW(7), .DW(32), .CNT_W(16)) dB (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(D),
    .ReadDataMem(rdB), .rd_valid(vB), .rd_cnt(rcB), .wr_cnt(wcB), .proto_err(peB));
  data_mem_responder #(.READ_LATENCY(1), .AW(7), .DW(32), .CNT_W(4)) dC (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(D),
    .ReadDataMem(rdC), .rd_valid(vC), .rd_cnt(rcC), .wr_cnt(wcC), .proto_err(peC));

  int unsigned checks = 0;
  int unsigned errors = 0;

  // model state
  logic [31:0] mmem [128];
  bit          mknown [128];
  int unsigned rdc, wrc;
  bit          perr;
  logic [31:0] exp1;
  bit          exp1_known, exp1_valid;
  int unsigned vcount;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int unsigned v, input int unsigned w);
    int unsigned m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    rdc = 0; wrc = 0; perr = 0;
    exp1 = '0; exp1_known = 1; exp1_valid = 0;
  endtask

  task automatic model_edge();
    bit w, r;
    if (!rst_n) return;
    w = !CEN && !WEN;
    r = !CEN && !OEN;
    exp1_valid = r;
    if (r) begin
      exp1       = w ? D : mmem[A];
      exp1_known = w || mknown[A];
    end
    if (w) begin
      mmem[A]   = D;
      mknown[A] = 1;
      wrc++;
    end
    if (r) rdc++;
    if (w && r) perr = 1;
  endtask

  task automatic chk_all();
    bit          v0;
    logic [31:0] e0;
    v0 = rst_n && !CEN && !OEN;
    e0 = '0;
    if (v0) e0 = mmem[A];
    cmp("A rd_valid", 32'(vA), 32'(exp1_valid));
    if (exp1_known) cmp("A rdata", rdA, exp1);
    cmp("A rd_cnt", 32'(rcA), sat(rdc, 16));
    cmp("A wr_cnt", 32'(wcA), sat(wrc, 16));
    cmp("A proto_err", 32'(peA), 32'(perr));
    cmp("B rd_valid", 32'(vB), 32'(v0));
    if (!v0 || mknown[A]) cmp("B rdata", rdB, e0);
    cmp("B rd_cnt", 32'(rcB), sat(rdc, 16));
    cmp("B wr_cnt", 32'(wcB), sat(wrc, 16));
    cmp("B proto_err", 32'(peB), 32'(perr));
    cmp("C rd_valid", 32'(vC), 32'(exp1_valid));
    if (exp1_known) cmp("C rdata", rdC, exp1);
    cmp("C rd_cnt", 32'(rcC), sat(rdc, 4));
    cmp("C wr_cnt", 32'(wcC), sat(wrc, 4));
    cmp("C proto_err", 32'(peC), 32'(perr));
    if (vA) vcount++;
  endtask

  // Inputs are driven just after a posedge. They are checked at the negedge and
  // fed to the model at the next posedge.
  task automatic half(input logic cen, input logic wen, input logic oen,
                      input logic [6:0] a, input logic [31:0] d);
    CEN = cen; WEN = wen; OEN = oen; A = a; D = d;
    @(negedge clk);
    chk_all();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle(input logic cen, input logic wen, input logic oen,
                       input logic [6:0] a, input logic [31:0] d);
    half(cen, wen, oen, a, d);
    finish_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    cmp("reset A rdata", rdA, 32'd0);
    cmp("reset A rd_valid", 32'(vA), 32'd0);
    cmp("reset B rdata", rdB, 32'd0);
    cmp("reset A proto_err", 32'(peA), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
    rst_n = 1'b1;

    // idle cycles: nothing moves
    repeat (10) cycle(1'b1, 1'($urandom), 1'($urandom), 7'($urandom), $urandom);
    cmp("idle rd_cnt", 32'(rcA), 32'd0);
    cmp("idle wr_cnt", 32'(wcA), 32'd0);

    // write 5, then read 5
    cycle(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
    half(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    cmp("L0 read5", rdB, 32'hDEADBEEF);
    finish_cycle();
    half(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    cmp("L1 read5", rdA, 32'hDEADBEEF);
    cmp("L1 read5 valid", 32'(vA), 32'd1);
    cmp("read5 rd_cnt", 32'(rcA), 32'd1);
    cmp("read5 wr_cnt", 32'(wcA), 32'd1);
    finish_cycle();

    // conflict on address 3
    cycle(1'b0, 1'b0, 1'b1, 7'd3, 32'h11);
    half(1'b0, 1'b0, 1'b0, 7'd3, 32'h22);
    cmp("L0 conflict old", rdB, 32'h11);
    finish_cycle();
    half(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    cmp("L1 conflict new", rdA, 32'h22);
    cmp("conflict proto_err", 32'(peA), 32'd1);
    cmp("conflict rd_cnt", 32'(rcA), 32'd2);
    cmp("conflict wr_cnt", 32'(wcA), 32'd3);
    finish_cycle();
    repeat (50) cycle(1'b0, 1'b1, 1'b0, 7'd3, $urandom);
    half(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    cmp("sticky proto_err", 32'(peA), 32'd1);
    cmp("mem3 after conflict", rdA, 32'h22);
    finish_cycle();

    // saturation after reset; memory survives reset
    do_reset();
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 7'd5, $urandom);
    half(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    cmp("sat C rd_cnt", 32'(rcC), 32'd15);
    cmp("sat C wr_cnt", 32'(wcC), 32'd0);
    cmp("sat A rd_cnt", 32'(rcA), 32'd20);
    cmp("sat mem5 kept", rdA, 32'hDEADBEEF);
    finish_cycle();

    // reset asserted between edges the cycle after a read
    cycle(1'b0, 1'b1, 1'b0, 7'd3, 32'h0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    cmp("midrst A rdata", rdA, 32'd0);
    cmp("midrst A rd_valid", 32'(vA), 32'd0);
    cmp("midrst A rd_cnt", 32'(rcA), 32'd0);
    cmp("midrst C rd_cnt", 32'(rcC), 32'd0);
    @(posedge clk); #1;
    cycle(1'b0, 1'b1, 1'b0, 7'd7, 32'h0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
    half(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    cmp("post-reset read5", rdA, 32'hDEADBEEF);
    finish_cycle();

    // streaming
    do_reset();
    for (int i = 0; i < 128; i++) cycle(1'b0, 1'b0, 1'b1, 7'(i), 32'h1000 + 32'(i));
    vcount = 0;
    for (int i = 0; i < 128; i++) cycle(1'b0, 1'b1, 1'b0, 7'(i), $urandom);
    half(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    cmp("stream valid cycles", vcount, 32'd128);
    cmp("stream rd_cnt", 32'(rcA), 32'd128);
    cmp("stream wr_cnt", 32'(wcA), 32'd128);
    finish_cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            7'($urandom), $urandom);
    end
    half(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
    finish_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
